poly_pair_source: RTL and testbench

Streaming source for the packed two-coefficient polynomial datapath. On `start`, it reads two polynomials word by word from two coefficient RAMs that share one read address. Each RAM word holds two 25-bit coefficients. The block presents each word pair as `din1`/`din2` qualified by `out_flag`, which is the framing the modular add/sub units take on their `in_flag`/`din1`/`din2` inputs. It sits between the polynomial RAMs and the coefficient-wise arithmetic units, and produces a `done` pulse once the last pair has been issued.

---
 rtl/poly_pair_source.sv | 132 +++++++++++++
 tb/tb_poly_pair_source.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/poly_pair_source.sv
// Streams two packed polynomials from a pair of shared-address coefficient RAMs as din1/din2/out_flag.
// Optional POLY_SRC_CHECK_EN builds a sticky per-coefficient range check against the latched modulus.
module poly_pair_source #(
   parameter int WORDS  = 256,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              q_mod_in,
   input  logic              hold,
   output logic              ren,
   output logic [ADDR_W-1:0] raddr,
   input  logic [49:0]       rdata1,
   input  logic [49:0]       rdata2,
   output logic [49:0]       din1,
   output logic [49:0]       din2,
   output logic              out_flag,
   output logic              q_mod,
   output logic              busy,
   output logic              done,
   output logic              err
);
   typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic              rd_vld_q, rd_vld_d;
   logic              out_flag_q, out_flag_d;
   logic [49:0]       din1_q, din1_d;
   logic [49:0]       din2_q, din2_d;
   logic              q_mod_q, q_mod_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              start_acc;

   // The done cycle is already IDLE, so a start there must be masked explicitly.
   assign start_acc = (state_q == IDLE) && start && !done_q;
   assign ren       = (state_q == FETCH) && !hold;
   assign raddr     = cnt_q;
   assign din1      = din1_q;
   assign din2      = din2_q;
   assign out_flag  = out_flag_q;
   assign q_mod     = q_mod_q;
   assign busy      = busy_q;
   assign done      = done_q;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      q_mod_d    = q_mod_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      rd_vld_d   = ren;
      out_flag_d = rd_vld_q;
      din1_d     = rd_vld_q ? rdata1 : '0;
      din2_d     = rd_vld_q ? rdata2 : '0;
      case (state_q)
         IDLE: begin
            if (start_acc) begin
               state_d = FETCH;
               cnt_d   = '0;
               q_mod_d = q_mod_in;
               busy_d  = 1'b1;
            end
         end
         FETCH: begin
            // Stop counting on the last issue so the address never wraps.
            if (ren) begin
               if (cnt_q == LAST_ADDR) state_d = DRAIN;
               else                    cnt_d   = cnt_q + 1'b1;
            end
         end
         DRAIN: begin
            if (!rd_vld_q) begin
               state_d = IDLE;
               done_d  = 1'b1;
               busy_d  = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         rd_vld_q   <= 1'b0;
         out_flag_q <= 1'b0;
         din1_q     <= '0;
         din2_q     <= '0;
         q_mod_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rd_vld_q   <= rd_vld_d;
         out_flag_q <= out_flag_d;
         din1_q     <= din1_d;
         din2_q     <= din2_d;
         q_mod_q    <= q_mod_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

`ifdef POLY_SRC_CHECK_EN
   logic        err_q, err_d;
   logic [24:0] q_val;
   logic        range_bad;

   always_comb begin
      q_val     = q_mod_q ? 25'd16515073 : 25'd33292289;
      range_bad = rd_vld_q && ((rdata1[49:25] >= q_val) || (rdata1[24:0] >= q_val) ||
                               (rdata2[49:25] >= q_val) || (rdata2[24:0] >= q_val));
      err_d     = start_acc ? 1'b0 : (err_q | range_bad);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) err_q <= 1'b0;
      else      err_q <= err_d;
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_poly_pair_source.sv
// Directed bench for poly_pair_source with WORDS=4; cycle 0 is the cycle start is high.
module tb_poly_pair_source;
   localparam int WORDS  = 4;
   localparam int ADDR_W = 2;
`ifdef POLY_SRC_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              start = 1'b0;
   logic              q_mod_in = 1'b0;
   logic              hold = 1'b0;
   logic              ren;
   logic [ADDR_W-1:0] raddr;
   logic [49:0]       rdata1 = '0;
   logic [49:0]       rdata2 = '0;
   logic [49:0]       din1, din2;
   logic              out_flag, q_mod, busy, done, err;
   logic [49:0]       ram_a [WORDS];
   logic [49:0]       ram_b [WORDS];
   int                checks = 0;
   int                failures = 0;

   poly_pair_source #(.WORDS(WORDS), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst), .start(start), .q_mod_in(q_mod_in), .hold(hold),
      .ren(ren), .raddr(raddr), .rdata1(rdata1), .rdata2(rdata2),
      .din1(din1), .din2(din2), .out_flag(out_flag), .q_mod(q_mod),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   // One-cycle-latency RAM pair
   always @(posedge clk) begin
      if (ren) begin
         rdata1 <= ram_a[raddr];
         rdata2 <= ram_b[raddr];
      end
   end

   function automatic logic [49:0] pk(input int hi, input int lo);
      logic [24:0] h, l;
      h = 25'(hi);
      l = 25'(lo);
      return {h, l};
   endfunction

   task automatic load_basic();
      for (int i = 0; i < WORDS; i++) begin
         ram_a[i] = pk(i, i + 1);
         ram_b[i] = '0;
      end
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if ({ren, raddr, din1, din2, out_flag, q_mod, busy, done, err} !== '0) begin
         failures++;
         $display("FAIL reset_outs got=%h exp=0", {ren, raddr, din1, din2, out_flag, q_mod, busy, done, err});
      end
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({ren, out_flag, busy, done, err} !== 5'b0) begin
         failures++;
         $display("FAIL reset_release got=%b exp=00000", {ren, out_flag, busy, done, err});
      end
   endtask

   task automatic test_basic();
      int idx = 0;
      logic ef, ed, eb, er;
      logic [49:0] e1;
      load_basic();
      @(posedge clk);
      #1 start = 1'b1; q_mod_in = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         ef = (c >= 3 && c <= 6); ed = (c == 7); eb = (c >= 1 && c <= 6); er = (c >= 1 && c <= 4);
         e1 = ef ? pk(idx, idx + 1) : '0;
         checks++;
         if ({out_flag, done, busy, ren} !== {ef, ed, eb, er}) begin
            failures++;
            $display("FAIL basic_ctl c=%0d got=%b exp=%b", c, {out_flag, done, busy, ren}, {ef, ed, eb, er});
         end
         if (er) begin
            checks++;
            if (raddr !== ADDR_W'(c - 1)) begin
               failures++;
               $display("FAIL basic_raddr c=%0d got=%0d exp=%0d", c, raddr, c - 1);
            end
         end
         checks++;
         if (din1 !== e1 || din2 !== 50'd0) begin
            failures++;
            $display("FAIL basic_data c=%0d got=%h/%h exp=%h/0", c, din1, din2, e1);
         end
         if (ef) idx++;
         @(posedge clk);
         #1 start = 1'b0;
      end
   endtask

   task automatic test_hold();
      int idx = 0, ri = 0;
      logic [15:0] flag_m = 16'h01C8;   // cycles 3,6,7,8
      logic [15:0] ren_m  = 16'h0072;   // cycles 1,4,5,6
      logic ef, er;
      logic [49:0] e1;
      load_basic();
      @(posedge clk);
      #1 start = 1'b1; hold = 1'b0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         ef = flag_m[c]; er = ren_m[c];
         e1 = ef ? pk(idx, idx + 1) : '0;
         checks++;
         if ({out_flag, ren, done} !== {ef, er, (c == 9)}) begin
            failures++;
            $display("FAIL hold_ctl c=%0d got=%b exp=%b", c, {out_flag, ren, done}, {ef, er, (c == 9)});
         end
         if (er) begin
            checks++;
            if (raddr !== ADDR_W'(ri)) begin
               failures++;
               $display("FAIL hold_raddr c=%0d got=%0d exp=%0d", c, raddr, ri);
            end
            ri++;
         end
         checks++;
         if (din1 !== e1) begin
            failures++;
            $display("FAIL hold_data c=%0d got=%h exp=%h", c, din1, e1);
         end
         if (ef) idx++;
         @(posedge clk);
         #1 start = 1'b0; hold = (c + 1 == 2) || (c + 1 == 3);
      end
      hold = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [31:0] ren_m  = 32'h0000_3C1E;  // 1-4 and 10-13
      logic [31:0] flag_m = 32'h0000_F078;  // 3-6 and 12-15
      logic [31:0] done_m = 32'h0001_0080;  // 7 and 16
      int ea;
      load_basic();
      @(posedge clk);
      #1 start = 1'b1;
      for (int c = 0; c < 18; c++) begin
         @(negedge clk);
         checks++;
         if ({ren, out_flag, done} !== {ren_m[c], flag_m[c], done_m[c]}) begin
            failures++;
            $display("FAIL b2b_ctl c=%0d got=%b exp=%b", c, {ren, out_flag, done}, {ren_m[c], flag_m[c], done_m[c]});
         end
         if (ren_m[c]) begin
            ea = (c <= 4) ? c - 1 : c - 10;
            checks++;
            if (raddr !== ADDR_W'(ea)) begin
               failures++;
               $display("FAIL b2b_raddr c=%0d got=%0d exp=%0d", c, raddr, ea);
            end
         end
         @(posedge clk);
         #1 start = (c + 1 <= 7) || (c + 1 == 9);
      end
      start = 1'b0;
   endtask

   task automatic test_reset_mid();
      load_basic();
      @(posedge clk);
      #1 start = 1'b1; q_mod_in = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({out_flag, q_mod, busy} !== 3'b111 || din1 !== pk(0, 1)) begin
         failures++;
         $display("FAIL mid_prereset got=%b/%h exp=111/%h", {out_flag, q_mod, busy}, din1, pk(0, 1));
      end
      @(posedge clk);
      #1 rst = 1'b0;
      #1;
      checks++;
      if ({ren, raddr, din1, din2, out_flag, q_mod, busy, done, err} !== '0) begin
         failures++;
         $display("FAIL mid_reset_outs got=%h exp=0", {ren, raddr, din1, din2, out_flag, q_mod, busy, done, err});
      end
      repeat (2) @(posedge clk);
      #1 rst = 1'b1; q_mod_in = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++;
         if ({done, busy, ren, out_flag} !== 4'b0) begin
            failures++;
            $display("FAIL mid_quiet c=%0d got=%b exp=0000", c, {done, busy, ren, out_flag});
         end
      end
      @(posedge clk);
      #1 start = 1'b1;
      for (int c = 0; c < 9; c++) begin
         @(negedge clk);
         if (c == 1) begin
            checks++;
            if (ren !== 1'b1 || raddr !== '0) begin
               failures++;
               $display("FAIL mid_restart_addr got=%b/%0d exp=1/0", ren, raddr);
            end
         end
         if (c == 3) begin
            checks++;
            if (out_flag !== 1'b1 || din1 !== pk(0, 1)) begin
               failures++;
               $display("FAIL mid_restart_data got=%b/%h exp=1/%h", out_flag, din1, pk(0, 1));
            end
         end
         checks++;
         if (done !== (c == 7)) begin
            failures++;
            $display("FAIL mid_restart_done c=%0d got=%b exp=%b", c, done, (c == 7));
         end
         @(posedge clk);
         #1 start = 1'b0;
      end
   endtask

   task automatic test_range_check();
      logic [49:0] exp1 [WORDS];
      logic [49:0] e1, e2;
      logic        ee;
      int          idx;
      load_basic();
      ram_a[0] = pk(0, 16515072);
      ram_a[2] = pk(16515073, 3);
      ram_b[1] = pk(7, 9);
      exp1[0] = pk(0, 16515072); exp1[1] = pk(1, 2); exp1[2] = pk(16515073, 3); exp1[3] = pk(3, 4);
      for (int pass = 0; pass < 2; pass++) begin
         idx = 0;
         @(posedge clk);
         #1 start = 1'b1; q_mod_in = (pass == 0);
         for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            if (pass == 0) ee = CHK && (c >= 5);
            else           ee = CHK && (c == 0);
            checks++;
            if (err !== ee) begin
               failures++;
               $display("FAIL err_p%0d c=%0d got=%b exp=%b", pass, c, err, ee);
            end
            if (c >= 1) begin
               checks++;
               if (q_mod !== (pass == 0)) begin
                  failures++;
                  $display("FAIL qmod_p%0d c=%0d got=%b exp=%b", pass, c, q_mod, (pass == 0));
               end
            end
            if (c >= 3 && c <= 6) begin
               e1 = exp1[idx];
               e2 = (idx == 1) ? pk(7, 9) : '0;
               checks++;
               if (out_flag !== 1'b1 || din1 !== e1 || din2 !== e2) begin
                  failures++;
                  $display("FAIL rng_data_p%0d c=%0d got=%b/%h/%h exp=1/%h/%h", pass, c, out_flag, din1, din2, e1, e2);
               end
               idx++;
            end
            @(posedge clk);
            #1 start = 1'b0;
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_hold();
      test_back_to_back();
      test_reset_mid();
      test_range_check();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
